// File: rtl/decoder_scan.sv
// Registered N-to-2^N one-hot decoder with enable and an auto-scan mode with programmable dwell.
// Optional per-channel disable mask is compiled in with `define DECODER_MASK_EN.
module decoder_scan #(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [DWELL_W-1:0]      dwell,
`ifdef DECODER_MASK_EN
  input  logic [(1<<SEL_W)-1:0]   mask,
`endif
  output logic [(1<<SEL_W)-1:0]   y,
  output logic [SEL_W-1:0]        cur_sel,
  output logic                    tick,
  output logic                    wrap
);

  localparam int N = 1 << SEL_W;

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  state_t             state_reg, state_next;
  logic [N-1:0]       y_reg;
  logic [SEL_W-1:0]   cur_sel_reg;
  logic               tick_reg, wrap_reg;
  logic [DWELL_W-1:0] cnt_reg;
  logic [N-1:0]       mask_i;

`ifdef DECODER_MASK_EN
  assign mask_i = mask;
`else
  assign mask_i = '0;
`endif

  function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] idx);
    return {{(N-1){1'b0}}, 1'b1} << idx;
  endfunction

  always_comb begin
    if (!en)
      state_next = IDLE;
    else if (mode)
      state_next = SCAN;
    else
      state_next = DIRECT;
  end

  // Nearest unmasked channel: loops run far-to-near so the closest candidate is written last.
  logic             adv_found, adv_wrap, ent_found;
  logic [SEL_W-1:0] adv_idx, ent_idx;
  logic [SEL_W:0]   adv_sum, ent_sum;

  always_comb begin
    adv_found = 1'b0;
    adv_idx   = cur_sel_reg;
    adv_wrap  = 1'b0;
    adv_sum   = '0;
    for (int k = N; k >= 1; k--) begin
      adv_sum = {1'b0, cur_sel_reg} + (SEL_W+1)'(k);
      if (!mask_i[adv_sum[SEL_W-1:0]]) begin
        adv_found = 1'b1;
        adv_idx   = adv_sum[SEL_W-1:0];
        adv_wrap  = adv_sum[SEL_W];
      end
    end
  end

  always_comb begin
    ent_found = 1'b0;
    ent_idx   = sel;
    ent_sum   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      ent_sum = {1'b0, sel} + (SEL_W+1)'(k);
      if (!mask_i[ent_sum[SEL_W-1:0]]) begin
        ent_found = 1'b1;
        ent_idx   = ent_sum[SEL_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      y_reg       <= '0;
      cur_sel_reg <= '0;
      tick_reg    <= 1'b0;
      wrap_reg    <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      state_reg <= state_next;
      tick_reg  <= 1'b0;
      wrap_reg  <= 1'b0;
      case (state_next)
        DIRECT: begin
          y_reg       <= mask_i[sel] ? '0 : onehot(sel);
          cur_sel_reg <= sel;
          cnt_reg     <= '0;
        end
        SCAN: begin
          if (state_reg != SCAN) begin
            cnt_reg <= '0;
            if (ent_found) begin
              cur_sel_reg <= ent_idx;
              y_reg       <= onehot(ent_idx);
            end else begin
              y_reg <= '0;
            end
          end else if (cnt_reg >= dwell) begin
            // >= rather than == so a dwell lowered below the running count still advances now
            cnt_reg <= '0;
            if (adv_found) begin
              cur_sel_reg <= adv_idx;
              y_reg       <= onehot(adv_idx);
              tick_reg    <= 1'b1;
              wrap_reg    <= adv_wrap;
            end else begin
              y_reg <= '0;
            end
          end else begin
            cnt_reg <= cnt_reg + DWELL_W'(1);
            if (mask_i[cur_sel_reg])
              y_reg <= '0;
          end
        end
        default: begin
          y_reg   <= '0;
          cnt_reg <= '0;
        end
      endcase
    end
  end

  assign y       = y_reg;
  assign cur_sel = cur_sel_reg;
  assign tick    = tick_reg;
  assign wrap    = wrap_reg;

endmodule
